exe_unit_spi_ctrl: RTL and testbench

EXE_UNIT_SPI_CTRL -- requirements
Module: exe_unit_spi_ctrl

---
 rtl/exe_unit_spi_ctrl.sv | 161 ++++++++++++++++
 tb/tb_exe_unit_spi_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_unit_spi_ctrl.sv
// SPI (mode 0) slave front end for an exe_unit. It receives {argA, argB, oper}
// MSB first, presents the registered operands to the unit, captures the
// result and flags, and shifts them back out on o_miso.
module exe_unit_spi_ctrl #(
    parameter int M = 8,
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_ss_n,
    input  logic         i_sck,
    input  logic         i_mosi,
    output logic         o_miso,
    output logic [M-1:0] o_argA,
    output logic [M-1:0] o_argB,
    output logic [N-1:0] o_oper,
    input  logic [M-1:0] i_result,
    input  logic         i_OF,
    input  logic         i_SF,
    input  logic         i_BF,
    input  logic         i_VF,
    output logic         o_busy,
    output logic         o_frame_err
);

    localparam int CMD_W = 2 * M + N;
    localparam int RSP_W = M + 4;
    localparam int CW    = $clog2(CMD_W + 1);
    localparam int TW    = $clog2(RSP_W + 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_W - 1);
    localparam logic [TW-1:0] RSP_LAST = TW'(RSP_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RX,
        S_EXEC,
        S_CAPT,
        S_TX,
        S_DONE
    } state_t;

    state_t state, state_nx;

    // Stages [1:0] synchronize; stage [2] holds the previous synchronized
    // value for edge detection.
    logic [2:0] ss_sr;
    logic [2:0] sck_sr;
    logic [1:0] mosi_sr;

    logic [CMD_W-1:0] rx_sr;
    logic [RSP_W-1:0] tx_sr;
    logic [CW-1:0]    bit_cnt;
    logic [TW-1:0]    tx_cnt;
    logic             seen_rise;

    logic ss_s, mosi_s, ss_fall, sck_rise, sck_fall, abort;

    assign ss_s     = ss_sr[1];
    assign mosi_s   = mosi_sr[1];
    assign ss_fall  = ss_sr[2] & ~ss_sr[1];
    assign sck_rise = ~sck_sr[2] & sck_sr[1];
    assign sck_fall = sck_sr[2] & ~sck_sr[1];
    assign abort    = ss_s && (state == S_RX || state == S_TX);

    // Synchronizers. Clearing the ss_n chain to 0 means a slave select that
    // is still held low after reset never looks like a fresh falling edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ss_sr   <= '0;
            sck_sr  <= '0;
            mosi_sr <= '0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old value of its neighbour, which is what makes this a shift chain.
            ss_sr   <= {ss_sr[1:0], i_ss_n};
            sck_sr  <= {sck_sr[1:0], i_sck};
            mosi_sr <= {mosi_sr[0], i_mosi};
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nx;
    end

    // Next-state logic; slave-select release takes priority over sck edges.
    always_comb begin
        // NOTE: a default assignment first keeps this block free of inferred latches.
        state_nx = state;
        case (state)
            S_IDLE: if (ss_fall) state_nx = S_RX;
            S_RX: begin
                if (ss_s) state_nx = S_IDLE;
                else if (sck_rise && bit_cnt == CMD_LAST) state_nx = S_EXEC;
            end
            S_EXEC: state_nx = S_CAPT;
            S_CAPT: state_nx = S_TX;
            S_TX: begin
                if (ss_s) state_nx = S_IDLE;
                else if (sck_rise && tx_cnt == RSP_LAST) state_nx = S_DONE;
            end
            S_DONE: if (ss_s) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state; only TX drives data onto o_miso.
    always_comb begin
        o_busy = (state != S_IDLE);
        o_miso = (state == S_TX) ? tx_sr[RSP_W-1] : 1'b0;
    end

    // Datapath: command shift-in, operand load, response capture and shift-out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_sr       <= '0;
            tx_sr       <= '0;
            bit_cnt     <= '0;
            tx_cnt      <= '0;
            seen_rise   <= 1'b0;
            o_argA      <= '0;
            o_argB      <= '0;
            o_oper      <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= abort;
            case (state)
                S_IDLE: begin
                    bit_cnt   <= '0;
                    tx_cnt    <= '0;
                    seen_rise <= 1'b0;
                end
                S_RX: begin
                    if (!ss_s && sck_rise) begin
                        rx_sr   <= {rx_sr[CMD_W-2:0], mosi_s};
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                S_EXEC: {o_argA, o_argB, o_oper} <= rx_sr;
                S_CAPT: begin
                    tx_sr     <= {i_result, i_OF, i_SF, i_BF, i_VF};
                    tx_cnt    <= '0;
                    seen_rise <= 1'b0;
                end
                S_TX: begin
                    if (!ss_s) begin
                        if (sck_rise) begin
                            tx_cnt    <= tx_cnt + TW'(1);
                            seen_rise <= 1'b1;
                        end else if (sck_fall && seen_rise) begin
                            tx_sr     <= tx_sr << 1;
                            seen_rise <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_exe_unit_spi_ctrl.sv
// Directed bench for exe_unit_spi_ctrl: SPI frames driven bit by bit with a
// fixed exe_unit stub whose result/flags are set per test.
module tb_exe_unit_spi_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ss_n, sck, mosi;
    logic       miso;
    logic [7:0] arg_a, arg_b, result;
    logic [3:0] oper;
    logic       of_f, sf_f, bf_f, vf_f;
    logic       busy, frame_err;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;

    exe_unit_spi_ctrl #(.M(8), .N(4)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_ss_n      (ss_n),
        .i_sck       (sck),
        .i_mosi      (mosi),
        .o_miso      (miso),
        .o_argA      (arg_a),
        .o_argB      (arg_b),
        .o_oper      (oper),
        .i_result    (result),
        .i_OF        (of_f),
        .i_SF        (sf_f),
        .i_BF        (bf_f),
        .i_VF        (vf_f),
        .o_busy      (busy),
        .o_frame_err (frame_err)
    );

    always #5 clk = ~clk;

    // Count every cycle the error strobe is seen high.
    always @(posedge clk) if (frame_err) err_cnt = err_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One sck period: low phase with mosi set, sample miso, then high phase.
    task automatic sck_pulse(input logic bit_in, output logic miso_seen);
        mosi = bit_in;
        wait_clk(8);
        miso_seen = miso;
        sck = 1'b1;
        wait_clk(8);
        sck = 1'b0;
    endtask

    // Drive npulses sck periods carrying {a, b, op}; collect the 12 response
    // bits and OR together anything seen on miso after bit 32.
    task automatic frame(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input int npulses, output logic [11:0] rsp, output logic tail);
        logic [19:0] cmd;
        logic        m;
        cmd  = {a, b, op};
        rsp  = '0;
        tail = 1'b0;
        for (int i = 0; i < npulses; i++) begin
            sck_pulse((i < 20) ? cmd[19-i] : 1'b0, m);
            if (i >= 20 && i < 32) rsp = {rsp[10:0], m};
            if (i >= 32) tail = tail | m;
        end
    endtask

    task automatic stub(input logic [7:0] r, input logic [3:0] f);
        result = r;
        {of_f, sf_f, bf_f, vf_f} = f;
    endtask

    initial begin
        logic [11:0] rsp;
        logic        tail, m;

        rst = 1'b1; ss_n = 1'b1; sck = 1'b0; mosi = 1'b0;
        stub(8'h00, 4'h0);

        // Reset with ss_n high.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_miso", 32'(miso), 32'h0);
        check("rst_argA", 32'(arg_a), 32'h0);
        check("rst_argB", 32'(arg_b), 32'h0);
        check("rst_oper", 32'(oper), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ferr", 32'(frame_err), 32'h0);
        wait_clk(4);

        // Full frame: 5 op 3, stub answers 0x08 with no flags.
        stub(8'h08, 4'b0000);
        err_cnt = 0;
        ss_n = 1'b0;
        wait_clk(8);
        check("a_busy_rx", 32'(busy), 32'h1);
        frame(8'h05, 8'h03, 4'h0, 32, rsp, tail);
        check("a_argA", 32'(arg_a), 32'h05);
        check("a_argB", 32'(arg_b), 32'h03);
        check("a_oper", 32'(oper), 32'h0);
        check("a_rsp", 32'(rsp), 32'h080);
        check("a_miso_done", 32'(miso), 32'h0);
        check("a_busy_done", 32'(busy), 32'h1);
        ss_n = 1'b1;
        wait_clk(8);
        check("a_busy_end", 32'(busy), 32'h0);
        check("a_ferr", 32'(err_cnt), 32'h0);

        // Abort after 10 command bits: operands must not change.
        err_cnt = 0;
        ss_n = 1'b0;
        wait_clk(8);
        frame(8'h77, 8'h66, 4'h9, 10, rsp, tail);
        ss_n = 1'b1;
        wait_clk(8);
        check("rx_abort_ferr", 32'(err_cnt), 32'h1);
        check("rx_abort_argA", 32'(arg_a), 32'h05);
        check("rx_abort_argB", 32'(arg_b), 32'h03);
        check("rx_abort_oper", 32'(oper), 32'h0);
        check("rx_abort_busy", 32'(busy), 32'h0);

        // Abort after 5 response bits: new operands stay. 0xA5 -> 1,0,1,0,0.
        stub(8'hA5, 4'b1010);
        err_cnt = 0;
        ss_n = 1'b0;
        wait_clk(8);
        frame(8'hFF, 8'h01, 4'hB, 25, rsp, tail);
        check("tx_abort_bits", 32'(rsp[4:0]), 32'h14);
        ss_n = 1'b1;
        wait_clk(8);
        check("tx_abort_ferr", 32'(err_cnt), 32'h1);
        check("tx_abort_argA", 32'(arg_a), 32'hFF);
        check("tx_abort_argB", 32'(arg_b), 32'h01);
        check("tx_abort_oper", 32'(oper), 32'hB);
        check("tx_abort_busy", 32'(busy), 32'h0);

        // 40 pulses in one window: pulses 33-40 ignored, no error at release.
        stub(8'h3C, 4'b0101);
        err_cnt = 0;
        ss_n = 1'b0;
        wait_clk(8);
        frame(8'h12, 8'h34, 4'hF, 40, rsp, tail);
        check("long_rsp", 32'(rsp), 32'h3C5);
        check("long_tail_miso", 32'(tail), 32'h0);
        check("long_oper", 32'(oper), 32'hF);
        ss_n = 1'b1;
        wait_clk(8);
        check("long_ferr", 32'(err_cnt), 32'h0);

        // Reset during bit 15 with ss_n held low.
        err_cnt = 0;
        ss_n = 1'b0;
        wait_clk(8);
        frame(8'hAA, 8'h55, 4'h3, 14, rsp, tail);
        mosi = 1'b1;
        wait_clk(8);
        sck = 1'b1;
        wait_clk(3);
        rst = 1'b1;
        wait_clk(1);
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_argA", 32'(arg_a), 32'h0);
        wait_clk(5);
        sck = 1'b0;
        for (int i = 0; i < 5; i++) sck_pulse(1'b1, m);
        check("mid_rst_ignored", 32'(busy), 32'h0);
        ss_n = 1'b1;
        wait_clk(8);
        check("mid_rst_ferr", 32'(err_cnt), 32'h0);
        stub(8'h99, 4'b1111);
        ss_n = 1'b0;
        wait_clk(8);
        frame(8'h5A, 8'hC3, 4'h6, 32, rsp, tail);
        check("post_rst_argA", 32'(arg_a), 32'h5A);
        check("post_rst_argB", 32'(arg_b), 32'hC3);
        check("post_rst_oper", 32'(oper), 32'h6);
        check("post_rst_rsp", 32'(rsp), 32'h99F);
        ss_n = 1'b1;
        wait_clk(8);
        check("post_rst_ferr", 32'(err_cnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
